// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand request channel, result channel, busy status.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per cycle, LSB first, with carry flop
// and valid/ready handshakes on operand and result sides.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clock,
  input logic           reset,
  serial_adder_if.slave io
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [WIDTH-1:0] w_a_d, w_b_d, w_sum_d;
  logic             r_carry, w_carry_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             w_bit;
  logic             w_idle, w_done;

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_sum_d   = r_sum;
    w_carry_d = r_carry;
    w_cnt_d   = r_cnt;
    w_bit     = r_a[0] ^ r_b[0] ^ r_carry;
    unique case (r_state)
      StIdle: begin
        if (io.in_valid) begin
          w_a_d     = io.in_a;
          w_b_d     = io.in_b;
          w_carry_d = io.in_cin;
          w_cnt_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_carry_d            = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        // Shift-then-insert avoids an empty slice when WIDTH is 1.
        w_sum_d              = r_sum >> 1;
        w_sum_d[WIDTH-1]     = w_bit;
        w_a_d                = r_a >> 1;
        w_b_d                = r_b >> 1;
        w_cnt_d              = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (io.out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_sum   <= w_sum_d;
      r_carry <= w_carry_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Outputs are masked while reset is high so nothing stale leaks before the reset edge.
  assign w_idle       = (r_state == StIdle) && !reset;
  assign w_done       = (r_state == StDone) && !reset;
  assign io.in_ready  = w_idle;
  assign io.out_valid = w_done;
  assign io.out_sum   = w_done ? r_sum : '0;
  assign io.out_cout  = w_done & r_carry;
  assign io.busy      = (r_state != StIdle) && !reset;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances compared each cycle against a
// transaction-level model, plus directed literal cases and a randomized stream.
module tb_serial_adder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clock(clock), .reset(reset), .io(if8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clock(clock), .reset(reset), .io(if1));

  // Model: per instance, an op is pending for WIDTH cycles, then its result is offered.
  logic       m_pend [2] = '{1'b0, 1'b0};
  int         m_left [2] = '{0, 0};
  logic [8:0] m_res  [2] = '{9'd0, 9'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mstep(input int i, input logic v, input logic r, input logic [8:0] res,
                       input int w);
    if (reset) begin
      m_pend[i] = 1'b0;
      m_left[i] = 0;
    end else if (!m_pend[i]) begin
      if (v) begin
        m_pend[i] = 1'b1;
        m_left[i] = w;
        m_res[i]  = res;
      end
    end else if (m_left[i] > 0) begin
      m_left[i]--;
    end else if (r) begin
      m_pend[i] = 1'b0;
    end
  endtask

  always @(posedge clock) begin
    mstep(0, if8.in_valid, if8.out_ready,
          9'(if8.in_a) + 9'(if8.in_b) + 9'(if8.in_cin), 8);
    mstep(1, if1.in_valid, if1.out_ready,
          9'(if1.in_a) + 9'(if1.in_b) + 9'(if1.in_cin), 1);
  end

  task automatic mcmp(input int i, input logic rdy, input logic vld, input logic bsy,
                      input logic [8:0] act);
    logic ev;
    ev = !reset && m_pend[i] && (m_left[i] == 0);
    chk($sformatf("dut%0d in_ready", i), 32'(rdy), 32'(!reset && !m_pend[i]));
    chk($sformatf("dut%0d out_valid", i), 32'(vld), 32'(ev));
    chk($sformatf("dut%0d busy", i), 32'(bsy), 32'(!reset && m_pend[i]));
    chk($sformatf("dut%0d {cout,sum}", i), 32'(act), ev ? 32'(m_res[i]) : 32'd0);
  endtask

  always @(negedge clock) begin
    mcmp(0, if8.in_ready, if8.out_valid, if8.busy, {if8.out_cout, if8.out_sum});
    mcmp(1, if1.in_ready, if1.out_valid, if1.busy, 9'({if1.out_cout, if1.out_sum}));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec, input int hold);
    int n;
    if8.out_ready = 1'b0;
    if8.in_a      = a;
    if8.in_b      = b;
    if8.in_cin    = cin;
    if8.in_valid  = 1'b1;
    n = 0;
    while (!if8.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("op8 ready before accept", 32'(if8.in_ready), 32'd1);
    tick();
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("op8 latency", 32'(n), 32'd8);
    chk("op8 sum literal", 32'(if8.out_sum), 32'(es));
    chk("op8 cout literal", 32'(if8.out_cout), 32'(ec));
    chk("op8 model literal", 32'(m_res[0]), 32'({ec, es}));
    for (int k = 0; k < hold; k++) begin
      if8.in_valid = k[0];
      if8.in_a     = 8'($urandom);
      tick();
      chk("hold out_valid", 32'(if8.out_valid), 32'd1);
      chk("hold sum", 32'(if8.out_sum), 32'(es));
      chk("hold in_ready", 32'(if8.in_ready), 32'd0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk("op8 released valid", 32'(if8.out_valid), 32'd0);
    chk("op8 released ready", 32'(if8.in_ready), 32'd1);
  endtask

  logic [1:0] ft [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    int n;
    int issued;
    int got;
    if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_cin = 1'b0;
    if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_cin = 1'b0;
    if1.out_ready = 1'b0;

    tick();
    chk("reset in_ready", 32'(if8.in_ready), 32'd0);
    chk("reset out_sum", 32'(if8.out_sum), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(if8.in_ready), 32'd1);

    op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 5);

    // Abandon an op mid-RUN.
    if8.in_a = 8'h77; if8.in_b = 8'h11; if8.in_cin = 1'b1; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid-run reset valid", 32'(if8.out_valid), 32'd0);
    chk("mid-run reset ready", 32'(if8.in_ready), 32'd1);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      if1.in_a = i[2]; if1.in_b = i[1]; if1.in_cin = i[0]; if1.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0;
      n = 0;
      while (!if1.out_valid && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("w1 latency %0d", i), 32'(n), 32'd1);
      chk($sformatf("w1 truth %0d", i), 32'({if1.out_cout, if1.out_sum}), 32'(ft[i]));
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
    end

    issued = 0;
    got    = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_cin = 1'($urandom);
          if8.in_valid = 1'b1;
          n = 0;
          while (!if8.in_ready && n < 200) begin
            tick();
            n++;
          end
          if (n >= 200) begin
            chk("rand accept timeout", 32'(n), 32'd0);
            break;
          end
          tick();
          if8.in_valid = 1'b0;
          issued++;
        end
      end
      begin
        for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
          if8.out_ready = ($urandom_range(0, 3) != 0);
          if (if8.out_valid && if8.out_ready) got++;
          tick();
        end
        if8.out_ready = 1'b0;
      end
    join
    chk("rand issued", 32'(issued), 32'd1000);
    chk("rand delivered", 32'(got), 32'd1000);
    repeat (12) tick();
    chk("rand final idle", 32'(if8.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
